// File: rtl/cvp14_pkg.sv
// Shared CVP14 execute-stage definitions: functype encoding, vector geometry
// and the vector memory sequencer state encoding.
package cvp14_pkg;

  localparam int unsigned VLEN   = 16;
  localparam int unsigned ELEM_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned FT_W   = 4;

  // Functype encoding shared with the picker
  localparam logic [FT_W-1:0] VADD = 4'b0000;
  localparam logic [FT_W-1:0] VDOT = 4'b0001;
  localparam logic [FT_W-1:0] SMUL = 4'b0010;
  localparam logic [FT_W-1:0] SST  = 4'b0011;
  localparam logic [FT_W-1:0] VLD  = 4'b0100;
  localparam logic [FT_W-1:0] VST  = 4'b0101;
  localparam logic [FT_W-1:0] SLL  = 4'b0110;
  localparam logic [FT_W-1:0] SLH  = 4'b0111;
  localparam logic [FT_W-1:0] NOP  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } vmem_state_e;

  function automatic logic is_vmem_op(input logic [FT_W-1:0] ft);
    return (ft == VLD) || (ft == VST);
  endfunction

endpackage

// File: rtl/vmem_addr_gen.sv
// Vector memory address generator: holds the transfer base and element
// counter and presents a registered word address of base + i.
module vmem_addr_gen
  import cvp14_pkg::*;
#(
  parameter int unsigned N_ELEM = VLEN,
  parameter int unsigned AW     = ADDR_W,
  localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             adv,
  input  logic [AW-1:0]    op1,
  input  logic [AW-1:0]    op2,
  output logic [AW-1:0]    mem_addr,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] i_nxt_c,
  output logic             last
);

  logic [AW-1:0]    base_q, base_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;

  // Address is recomputed from next base/count so it is valid from the first RUN cycle
  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    if (load) begin
      base_d = op1 + op2;
      cnt_d  = '0;
    end else if (adv) begin
      cnt_d = cnt_q + IDX_W'(1);
    end
    addr_d = base_d + AW'(cnt_d);
    last_d = (cnt_d == IDX_W'(N_ELEM - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      base_q <= base_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign mem_addr = addr_q;
  assign i        = cnt_q;
  assign i_nxt_c  = cnt_d;
  assign last     = last_q;

endmodule

// File: rtl/vector_mem_seq.sv
// Vector memory sequencer: moves one vector between the VRF and the 16-bit
// memory port one element per beat. `VMEM_STALL_EN enables mem_rdy back-pressure.
module vector_mem_seq #(
  parameter int unsigned VLEN   = cvp14_pkg::VLEN,
  parameter int unsigned ELEM_W = cvp14_pkg::ELEM_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [cvp14_pkg::FT_W-1:0]   functype,
  input  logic [cvp14_pkg::ADDR_W-1:0] op1,
  input  logic [cvp14_pkg::ADDR_W-1:0] op2,
  input  logic [VLEN*ELEM_W-1:0]       st_vec,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [cvp14_pkg::ADDR_W-1:0] mem_addr,
  output logic [ELEM_W-1:0]            mem_wdata,
  input  logic                         mem_rdy,
  input  logic [ELEM_W-1:0]            mem_rdata,
  output logic [VLEN*ELEM_W-1:0]       ld_vec,
  output logic                         vreg_we,
  output logic                         busy,
  output logic                         done
);

  import cvp14_pkg::*;

  localparam int unsigned VEC_W = VLEN * ELEM_W;
  localparam int unsigned IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1;

  vmem_state_e state_q, state_d;

  logic             is_ld_q, is_ld_d;
  logic [VEC_W-1:0] st_q, st_d;
  logic [VEC_W-1:0] ld_q, ld_d;
  logic             cap_q, cap_d;
  logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [ELEM_W-1:0] mem_wdata_q, mem_wdata_d;
  logic             vreg_we_q, vreg_we_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             rdy_eff_c;
  logic             accept_c;
  logic             load_c;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt_c;
  logic             last;

`ifdef VMEM_STALL_EN
  assign rdy_eff_c = mem_rdy;
`else
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
  assign rdy_eff_c      = 1'b1;
`endif

  assign accept_c = (state_q == ST_RUN) && rdy_eff_c;

  vmem_addr_gen #(
    .N_ELEM (VLEN),
    .AW     (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .adv      (accept_c),
    .op1      (op1),
    .op2      (op2),
    .mem_addr (mem_addr),
    .i        (idx),
    .i_nxt_c  (idx_nxt_c),
    .last     (last)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    is_ld_d = is_ld_q;
    st_d    = st_q;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && is_vmem_op(functype)) begin
          load_c  = 1'b1;
          is_ld_d = (functype == VLD);
          st_d    = st_vec;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept_c && last) begin
          state_d = is_ld_q ? ST_DRAIN : ST_DONE;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state; read data lands one cycle after its beat
  always_comb begin
    mem_req_d   = (state_d == ST_RUN);
    mem_we_d    = (state_d == ST_RUN) && !is_ld_d;
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    vreg_we_d   = (state_d == ST_DONE) && is_ld_d;
    mem_wdata_d = mem_wdata_q;
    if ((state_d == ST_RUN) && !is_ld_d) begin
      mem_wdata_d = st_d[32'(idx_nxt_c) * ELEM_W +: ELEM_W];
    end
    cap_d     = accept_c && is_ld_q;
    cap_idx_d = idx;
    ld_d      = ld_q;
    if (cap_q) begin
      ld_d[32'(cap_idx_q) * ELEM_W +: ELEM_W] = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      is_ld_q     <= 1'b0;
      st_q        <= '0;
      ld_q        <= '0;
      cap_q       <= 1'b0;
      cap_idx_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vreg_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_ld_q     <= is_ld_d;
      st_q        <= st_d;
      ld_q        <= ld_d;
      cap_q       <= cap_d;
      cap_idx_q   <= cap_idx_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vreg_we_q   <= vreg_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign ld_vec    = ld_q;
  assign vreg_we   = vreg_we_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_vector_mem_seq.sv
// Scoreboard bench for vector_mem_seq: stimulus pushes expected beats/completions,
// a negedge monitor pops and compares; a small memory answers read beats.
`timescale 1ns/1ps
module tb_vector_mem_seq;
  import cvp14_pkg::*;

`ifdef VMEM_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   functype = NOP;
  logic [15:0]  op1 = '0;
  logic [15:0]  op2 = '0;
  logic [255:0] st_vec = '0;
  logic         mem_req, mem_we;
  logic [15:0]  mem_addr, mem_wdata;
  logic         mem_rdy = 1'b1;
  logic [15:0]  mem_rdata = 16'hDEAD;
  logic [255:0] ld_vec;
  logic         vreg_we, busy, done;

  vector_mem_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .functype(functype),
    .op1(op1), .op2(op2), .st_vec(st_vec),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
    .ld_vec(ld_vec), .vreg_we(vreg_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] addr; logic [15:0] data; } beat_t;
  typedef struct { int cyc; logic ld; } done_t;

  beat_t        exp_wr[$];
  beat_t        exp_hold[$];
  logic [15:0]  exp_rd[$];
  done_t        exp_done[$];
  logic [255:0] exp_ld[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  logic        rd_pend = 1'b0;
  logic [15:0] rd_addr = '0;

  // Monitor: pops expectations whenever the DUT presents a beat, stall or completion
  always @(negedge clk) begin
    beat_t b;
    done_t d;
    rd_pend = 1'b0;
    if (rst_n) begin
      if (mem_req && (mem_rdy || !STALL)) begin
        if (mem_we) begin
          chk("write beat expected", 256'(exp_wr.size() != 0), 256'(1));
          if (exp_wr.size() != 0) begin
            b = exp_wr.pop_front();
            chk("write addr", 256'(mem_addr), 256'(b.addr));
            chk("write data", 256'(mem_wdata), 256'(b.data));
          end
        end else begin
          chk("read beat expected", 256'(exp_rd.size() != 0), 256'(1));
          if (exp_rd.size() != 0) chk("read addr", 256'(mem_addr), 256'(exp_rd.pop_front()));
          rd_pend = 1'b1;
          rd_addr = mem_addr;
        end
      end else if (mem_req && STALL) begin
        chk("stall expected", 256'(exp_hold.size() != 0), 256'(1));
        if (exp_hold.size() != 0) begin
          b = exp_hold.pop_front();
          chk("stall addr held", 256'(mem_addr), 256'(b.addr));
          chk("stall data held", 256'(mem_wdata), 256'(b.data));
          chk("stall we held", 256'(mem_we), 256'(1));
        end
      end
      if (done || vreg_we) begin
        chk("completion expected", 256'(exp_done.size() != 0), 256'(1));
        if (exp_done.size() != 0) begin
          d = exp_done.pop_front();
          chk("done cycle", 256'(cyc), 256'(d.cyc));
          chk("done/vreg_we", 256'({done, vreg_we}), 256'({1'b1, d.ld}));
          if (d.ld && exp_ld.size() != 0) chk("ld_vec", ld_vec, exp_ld.pop_front());
        end
      end
    end
  end

  // Memory model: read data valid in the cycle after the accepted read beat
  always @(posedge clk) begin
    #1;
    mem_rdata = rd_pend ? (rd_addr ^ 16'h5555) : 16'hDEAD;
  end

  task automatic issue(input logic [3:0] ft, input logic [15:0] a, input logic [15:0] b,
                       input logic [255:0] v, output int c0);
    @(posedge clk); #1;
    functype = ft; op1 = a; op2 = b; st_vec = v; start = 1'b1;
    c0 = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0; functype = NOP;
  endtask

  task automatic expect_store(input logic [15:0] base, input logic [255:0] v, input int done_cyc);
    for (int i = 0; i < 16; i++) begin
      exp_wr.push_back('{addr: base + 16'(i), data: v[16*i +: 16]});
    end
    exp_done.push_back('{cyc: done_cyc, ld: 1'b0});
  endtask

  task automatic expect_load(input logic [15:0] base, input int done_cyc);
    logic [255:0] v;
    logic [15:0]  a;
    for (int i = 0; i < 16; i++) begin
      a = base + 16'(i);
      exp_rd.push_back(a);
      v[16*i +: 16] = a ^ 16'h5555;
    end
    exp_ld.push_back(v);
    exp_done.push_back('{cyc: done_cyc, ld: 1'b1});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 256'(busy), 256'(0));
    repeat (2) @(posedge clk);
    #1;
    chk({name, " queues drained"},
        256'(exp_wr.size() + exp_rd.size() + exp_done.size() + exp_ld.size() + exp_hold.size()),
        256'(0));
  endtask

  function automatic logic [255:0] ramp(input logic [15:0] b);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = b + 16'(i);
    return v;
  endfunction

  initial begin
    int c0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("reset ctrl outputs", 256'({mem_req, mem_we, vreg_we, done, busy}), 256'(0));
    chk("reset addr/wdata", 256'({mem_addr, mem_wdata}), 256'(0));
    chk("reset ld_vec", ld_vec, 256'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Store with negative offset: 0x0100 + (-2) = 0x00FE
    issue(VST, 16'h0100, 16'hFFFE, ramp(16'hA000), c0);
    expect_store(16'h00FE, ramp(16'hA000), c0 + 16);
    wait_idle("store idle");

    // Load 0x0203.., then load across the 0xFFFF wrap
    issue(VLD, 16'h0200, 16'h0003, '0, c0);
    expect_load(16'h0203, c0 + 17);
    wait_idle("load idle");
    issue(VLD, 16'hFFF8, 16'h0000, '0, c0);
    expect_load(16'hFFF8, c0 + 17);
    wait_idle("wrap load idle");
    chk("ld_vec held after load", ld_vec[255:240], 16'h0007 ^ 16'h5555);

    // Store with mem_rdy low for 3 cycles at beat 5
    issue(VST, 16'h1000, 16'h0005, ramp(16'h5A00), c0);
    expect_store(16'h1005, ramp(16'h5A00), c0 + 16 + (STALL ? 3 : 0));
    repeat (5) @(posedge clk);
    #1;
    if (STALL) for (int k = 0; k < 3; k++) exp_hold.push_back('{addr: 16'h100A, data: 16'h5A05});
    mem_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mem_rdy = 1'b1;
    wait_idle("stall store idle");

    // Non-memory functype is ignored; start during busy is ignored
    issue(SLL, 16'h0400, 16'h0000, '0, c0);
    repeat (2) @(posedge clk);
    #1;
    chk("SLL start ignored", 256'({busy, mem_req}), 256'(0));
    issue(VLD, 16'h0040, 16'h0000, '0, c0);
    expect_load(16'h0040, c0 + 17);
    repeat (3) @(posedge clk);
    #1;
    functype = VLD; op1 = 16'h7777; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; functype = NOP;
    wait_idle("busy start idle");
    repeat (20) @(posedge clk);
    #1;
    chk("no second transfer", 256'({busy, mem_req, done}), 256'(0));

    // Reset at beat 8 of a load aborts it
    issue(VLD, 16'h0300, 16'h0010, '0, c0);
    for (int i = 0; i < 8; i++) exp_rd.push_back(16'h0310 + 16'(i));
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort ctrl outputs", 256'({mem_req, mem_we, vreg_we, done, busy}), 256'(0));
    chk("abort addr/wdata", 256'({mem_addr, mem_wdata}), 256'(0));
    chk("abort ld_vec", ld_vec, 256'(0));
    chk("abort beats seen", 256'(exp_rd.size()), 256'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    issue(VLD, 16'h0500, 16'hFFFF, '0, c0);
    expect_load(16'h04FF, c0 + 17);
    wait_idle("post-reset load idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
